// File: rtl/result_collector.sv
// result_collector: gathers the sa and custom 2x2 result matrices, saturates
// each 16-bit word to a byte, and publishes all eight bytes to the display
// stage with a one-cycle reg_en strobe.
module result_collector #(
    parameter int unsigned SAT_MAX = 255
) (
    input  logic        clock_100Mhz,
    input  logic        reset,
    input  logic        start,
    input  logic        sa_valid,
    input  logic [15:0] sa_data,
    input  logic        cu_valid,
    input  logic [15:0] cu_data,
    input  logic        display_done,
    output logic [7:0]  c11_sa,
    output logic [7:0]  c12_sa,
    output logic [7:0]  c21_sa,
    output logic [7:0]  c22_sa,
    output logic [7:0]  c11_custom,
    output logic [7:0]  c12_custom,
    output logic [7:0]  c21_custom,
    output logic [7:0]  c22_custom,
    output logic        reg_en,
    output logic        busy,
    output logic        error
);

    localparam int unsigned DATA_W  = 16;
    localparam int unsigned BYTE_W  = 8;
    localparam int unsigned CNT_W   = 3;
    localparam int unsigned SLOTS   = 4;
    localparam logic [DATA_W-1:0] SAT_MAX_W  = DATA_W'(SAT_MAX);
    localparam logic [CNT_W-1:0]  CNT_FULL   = CNT_W'(SLOTS);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_COLLECT,
        ST_PUBLISH,
        ST_WAIT_DONE
    } state_t;

    state_t state_q, state_d;

    logic [CNT_W-1:0]  sa_cnt_q, sa_cnt_d;
    logic [CNT_W-1:0]  cu_cnt_q, cu_cnt_d;
    logic [BYTE_W-1:0] sa_shadow_q [SLOTS];
    logic [BYTE_W-1:0] cu_shadow_q [SLOTS];
    logic [BYTE_W-1:0] sa_shadow_d [SLOTS];
    logic [BYTE_W-1:0] cu_shadow_d [SLOTS];

    logic sa_acc, cu_acc;
    logic sa_ovf, cu_ovf;
    logic collect_done;
    logic restart;

    // Clamp a result word to the saturation ceiling (full-width compare).
    function automatic logic [BYTE_W-1:0] sat_byte(input logic [DATA_W-1:0] d);
        if (d > SAT_MAX_W) begin
            return BYTE_W'(SAT_MAX_W);
        end
        return d[BYTE_W-1:0];
    endfunction

    // Beat acceptance, overflow detection and next counter/shadow values.
    always_comb begin
        sa_acc = (state_q == ST_COLLECT) && sa_valid && (sa_cnt_q < CNT_FULL);
        cu_acc = (state_q == ST_COLLECT) && cu_valid && (cu_cnt_q < CNT_FULL);
        sa_ovf = (state_q == ST_COLLECT) && sa_valid && (sa_cnt_q == CNT_FULL);
        cu_ovf = (state_q == ST_COLLECT) && cu_valid && (cu_cnt_q == CNT_FULL);

        sa_cnt_d = sa_acc ? sa_cnt_q + CNT_W'(1) : sa_cnt_q;
        cu_cnt_d = cu_acc ? cu_cnt_q + CNT_W'(1) : cu_cnt_q;

        sa_shadow_d = sa_shadow_q;
        cu_shadow_d = cu_shadow_q;
        if (sa_acc) begin
            sa_shadow_d[sa_cnt_q[1:0]] = sat_byte(sa_data);
        end
        if (cu_acc) begin
            cu_shadow_d[cu_cnt_q[1:0]] = sat_byte(cu_data);
        end

        // Completion counts beats accepted on this same edge.
        collect_done = (sa_cnt_d == CNT_FULL) && (cu_cnt_d == CNT_FULL);
        restart      = start && ((state_q == ST_IDLE) || (state_q == ST_COLLECT));
    end

    // Next-state selection; a start in COLLECT restarts instead of publishing.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:      if (start) state_d = ST_COLLECT;
            ST_COLLECT:   if (!start && collect_done) state_d = ST_PUBLISH;
            ST_PUBLISH:   state_d = ST_WAIT_DONE;
            ST_WAIT_DONE: if (display_done) state_d = ST_IDLE;
            default:      state_d = ST_IDLE;
        endcase
    end

    // State, counters, shadow registers and registered outputs.
    always_ff @(posedge clock_100Mhz or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            sa_cnt_q   <= '0;
            cu_cnt_q   <= '0;
            for (int i = 0; i < SLOTS; i++) begin
                sa_shadow_q[i] <= '0;
                cu_shadow_q[i] <= '0;
            end
            c11_sa     <= '0;
            c12_sa     <= '0;
            c21_sa     <= '0;
            c22_sa     <= '0;
            c11_custom <= '0;
            c12_custom <= '0;
            c21_custom <= '0;
            c22_custom <= '0;
            reg_en     <= 1'b0;
            busy       <= 1'b0;
            error      <= 1'b0;
        end else begin
            state_q <= state_d;
            busy    <= (state_d != ST_IDLE);
            reg_en  <= 1'b0;
            if (restart) begin
                sa_cnt_q <= '0;
                cu_cnt_q <= '0;
                error    <= 1'b0;
            end else if (state_q == ST_COLLECT) begin
                sa_cnt_q    <= sa_cnt_d;
                cu_cnt_q    <= cu_cnt_d;
                sa_shadow_q <= sa_shadow_d;
                cu_shadow_q <= cu_shadow_d;
                if (sa_ovf || cu_ovf) begin
                    error <= 1'b1;
                end
                if (collect_done) begin
                    c11_sa     <= sa_shadow_d[0];
                    c12_sa     <= sa_shadow_d[1];
                    c21_sa     <= sa_shadow_d[2];
                    c22_sa     <= sa_shadow_d[3];
                    c11_custom <= cu_shadow_d[0];
                    c12_custom <= cu_shadow_d[1];
                    c21_custom <= cu_shadow_d[2];
                    c22_custom <= cu_shadow_d[3];
                    reg_en     <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_result_collector.sv
// Directed bench for result_collector with a publish scoreboard.
module tb_result_collector;

    logic        clock_100Mhz = 1'b0;
    logic        reset;
    logic        start;
    logic        sa_valid;
    logic [15:0] sa_data;
    logic        cu_valid;
    logic [15:0] cu_data;
    logic        display_done;
    logic [7:0]  c11_sa, c12_sa, c21_sa, c22_sa;
    logic [7:0]  c11_custom, c12_custom, c21_custom, c22_custom;
    logic        reg_en;
    logic        busy;
    logic        error;

    int checks   = 0;
    int failures = 0;
    int regen_cnt = 0;
    int base;
    logic [63:0] exp_q [$];

    result_collector #(.SAT_MAX(255)) dut (
        .clock_100Mhz (clock_100Mhz),
        .reset        (reset),
        .start        (start),
        .sa_valid     (sa_valid),
        .sa_data      (sa_data),
        .cu_valid     (cu_valid),
        .cu_data      (cu_data),
        .display_done (display_done),
        .c11_sa       (c11_sa),
        .c12_sa       (c12_sa),
        .c21_sa       (c21_sa),
        .c22_sa       (c22_sa),
        .c11_custom   (c11_custom),
        .c12_custom   (c12_custom),
        .c21_custom   (c21_custom),
        .c22_custom   (c22_custom),
        .reg_en       (reg_en),
        .busy         (busy),
        .error        (error)
    );

    always #5 clock_100Mhz = ~clock_100Mhz;

    function automatic logic [63:0] outs();
        return {c11_sa, c12_sa, c21_sa, c22_sa,
                c11_custom, c12_custom, c21_custom, c22_custom};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one edge, sample #1 later, and score any publish strobe.
    task automatic step();
        logic [63:0] e;
        @(posedge clock_100Mhz);
        #1;
        if (reg_en === 1'b1) begin
            regen_cnt++;
            if (exp_q.size() == 0) begin
                chk("unexpected_reg_en", 64'd1, 64'd0);
            end else begin
                e = exp_q.pop_front();
                chk("publish_data", outs(), e);
            end
        end
    endtask

    task automatic beat(input logic sv, input int sd, input logic cv, input int cd);
        sa_valid = sv;
        sa_data  = 16'(sd);
        cu_valid = cv;
        cu_data  = 16'(cd);
        step();
        sa_valid = 1'b0;
        cu_valid = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    // Leave WAIT_DONE: PUBLISH->WAIT_DONE edge, then one edge seeing display_done.
    task automatic finish_display();
        step();
        display_done = 1'b1;
        step();
        chk("busy_after_done", 64'(busy), 64'd0);
        display_done = 1'b0;
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; sa_valid = 1'b0; sa_data = '0;
        cu_valid = 1'b0; cu_data = '0; display_done = 1'b0;
        repeat (3) step();
        reset = 1'b0;
        step();
        chk("reset_outs",   outs(), 64'd0);
        chk("reset_reg_en", 64'(reg_en), 64'd0);
        chk("reset_busy",   64'(busy), 64'd0);
        chk("reset_error",  64'(error), 64'd0);

        // Sequential streams: sa 1..4 then cu 5..8.
        base = regen_cnt;
        pulse_start();
        chk("t1_busy_rise", 64'(busy), 64'd1);
        exp_q.push_back({8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8});
        for (int i = 1; i <= 4; i++) beat(1'b1, i, 1'b0, 0);
        for (int i = 5; i <= 7; i++) beat(1'b0, 0, 1'b1, i);
        chk("t1_no_early_reg_en", 64'(reg_en), 64'd0);
        beat(1'b0, 0, 1'b1, 8);
        chk("t1_reg_en_latency", 64'(reg_en), 64'd1);
        chk("t1_error", 64'(error), 64'd0);
        step();
        chk("t1_reg_en_one_cycle", 64'(reg_en), 64'd0);
        chk("t1_busy_wait", 64'(busy), 64'd1);
        display_done = 1'b1;
        step();
        chk("t1_busy_fall", 64'(busy), 64'd0);
        display_done = 1'b0;
        chk("t1_regen_count", 64'(regen_cnt - base), 64'd1);

        // Simultaneous streams with saturation; display_done high on WAIT_DONE entry.
        base = regen_cnt;
        pulse_start();
        exp_q.push_back({8'd255, 8'd255, 8'd255, 8'd0, 8'd255, 8'd10, 8'd254, 8'd255});
        beat(1'b1, 300, 1'b1, 65535);
        beat(1'b1, 255, 1'b1, 10);
        beat(1'b1, 256, 1'b1, 254);
        beat(1'b1, 0,   1'b1, 1000);
        chk("t2_reg_en", 64'(reg_en), 64'd1);
        display_done = 1'b1;
        step();
        chk("t2_busy_in_wait", 64'(busy), 64'd1);
        step();
        chk("t2_busy_after_one_wait", 64'(busy), 64'd0);
        display_done = 1'b0;
        chk("t2_regen_count", 64'(regen_cnt - base), 64'd1);

        // Fifth sa beat overflows; start in WAIT_DONE is ignored.
        base = regen_cnt;
        pulse_start();
        chk("t3_error_cleared", 64'(error), 64'd0);
        exp_q.push_back({8'd21, 8'd22, 8'd23, 8'd24, 8'd25, 8'd26, 8'd27, 8'd28});
        for (int i = 21; i <= 24; i++) beat(1'b1, i, 1'b0, 0);
        chk("t3_error_before_ovf", 64'(error), 64'd0);
        beat(1'b1, 9, 1'b0, 0);
        chk("t3_error_ovf", 64'(error), 64'd1);
        for (int i = 25; i <= 28; i++) beat(1'b0, 0, 1'b1, i);
        chk("t3_reg_en", 64'(reg_en), 64'd1);
        for (int i = 0; i < 20; i++) begin
            start = (i == 10);
            sa_valid = (i == 5);
            step();
        end
        start = 1'b0;
        sa_valid = 1'b0;
        chk("t3_busy_held", 64'(busy), 64'd1);
        chk("t3_error_sticky", 64'(error), 64'd1);
        display_done = 1'b1;
        step();
        chk("t3_busy_fall", 64'(busy), 64'd0);
        display_done = 1'b0;
        step();
        chk("t3_outs_hold", outs(), {8'd21, 8'd22, 8'd23, 8'd24, 8'd25, 8'd26, 8'd27, 8'd28});
        chk("t3_regen_count", 64'(regen_cnt - base), 64'd1);

        // Reset mid-collection aborts, then a normal collection follows.
        base = regen_cnt;
        pulse_start();
        beat(1'b1, 41, 1'b0, 0);
        beat(1'b1, 42, 1'b0, 0);
        #2;
        reset = 1'b1;
        #1;
        chk("t4_async_outs", outs(), 64'd0);
        chk("t4_async_busy", 64'(busy), 64'd0);
        chk("t4_async_error", 64'(error), 64'd1 - 64'd1);
        step();
        reset = 1'b0;
        beat(1'b1, 43, 1'b1, 44);
        beat(1'b1, 45, 1'b1, 46);
        step();
        chk("t4_no_reg_en_after_reset", 64'(regen_cnt - base), 64'd0);
        chk("t4_idle", 64'(busy), 64'd0);
        pulse_start();
        exp_q.push_back({8'd51, 8'd52, 8'd53, 8'd54, 8'd55, 8'd56, 8'd57, 8'd58});
        for (int i = 0; i < 4; i++) begin
            beat(1'b1, 51 + i, 1'b1, 55 + i);
            if (i < 3) step();
        end
        chk("t4_reg_en", 64'(reg_en), 64'd1);
        finish_display();
        chk("t4_regen_count", 64'(regen_cnt - base), 64'd1);

        // Restart mid-collection; only the new set is published.
        base = regen_cnt;
        pulse_start();
        for (int i = 61; i <= 63; i++) beat(1'b1, i, 1'b0, 0);
        pulse_start();
        chk("t5_busy_after_restart", 64'(busy), 64'd1);
        exp_q.push_back({8'd11, 8'd12, 8'd13, 8'd14, 8'd15, 8'd16, 8'd17, 8'd18});
        for (int i = 11; i <= 14; i++) beat(1'b1, i, 1'b0, 0);
        for (int i = 15; i <= 18; i++) beat(1'b0, 0, 1'b1, i);
        chk("t5_reg_en", 64'(reg_en), 64'd1);
        finish_display();
        repeat (3) step();
        chk("t5_regen_count", 64'(regen_cnt - base), 64'd1);
        chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
